// File: rtl/sbox_round_ctrl.sv
// sbox_round_ctrl: nibble-serial substitution-permutation round engine.
// Each block is XORed with its key on load. Each round then sends the four
// nibbles through the external S-box, one per cycle. After that it applies
// a fixed bit permutation and XORs the round key back in.
// Optional build macro: KEY_ROTATE_EN. When it is defined, the round key
// rotates left by one nibble at the start of every permutation cycle.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// SUB   | substituting nibble nib through the external S-box
// PERM  | bit permutation plus round-key XOR, then next round or finish
// DONE  | result presented on out_data until out_ready
module sbox_round_ctrl #(
  parameter int ROUNDS = 4,
  parameter int WIDTH  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [15:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [3:0]  sbox_in,
  input  logic [3:0]  sbox_out,
  output logic        busy
);

  if (WIDTH != 16) begin : g_bad_width
    $error("sbox_round_ctrl: WIDTH must be 16");
  end
  if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
    $error("sbox_round_ctrl: ROUNDS must be in 1..15");
  end

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    PERM = 2'd2,
    DONE = 2'd3
  } fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [15:0] state_reg_q, state_reg_d;
  logic [15:0] key_reg_q, key_reg_d;
  logic [15:0] out_data_q, out_data_d;
  logic [1:0]  nib_q, nib_d;
  logic [3:0]  rnd_q, rnd_d;
  logic [15:0] perm_w;
  logic [15:0] key_next;
  logic [3:0]  sbox_nib;

  // Output bit j takes substituted bit (4*j) mod 15, which is the inverse of i -> 4*i mod 15.
  assign perm_w = {state_reg_q[15], state_reg_q[11], state_reg_q[7],  state_reg_q[3],
                   state_reg_q[14], state_reg_q[10], state_reg_q[6],  state_reg_q[2],
                   state_reg_q[13], state_reg_q[9],  state_reg_q[5],  state_reg_q[1],
                   state_reg_q[12], state_reg_q[8],  state_reg_q[4],  state_reg_q[0]};

`ifdef KEY_ROTATE_EN
  assign key_next = {key_reg_q[11:0], key_reg_q[15:12]};
`else
  assign key_next = key_reg_q;
`endif

  // Select the nibble currently being substituted.
  always_comb begin
    sbox_nib = 4'h0;
    case (nib_q)
      2'd0: sbox_nib = state_reg_q[3:0];
      2'd1: sbox_nib = state_reg_q[7:4];
      2'd2: sbox_nib = state_reg_q[11:8];
      2'd3: sbox_nib = state_reg_q[15:12];
      default: sbox_nib = 4'h0;
    endcase
  end

  assign sbox_in   = (fsm_q == SUB) ? sbox_nib : 4'h0;
  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q == SUB) || (fsm_q == PERM);
  assign out_data  = out_data_q;

  // Next-state and datapath update for the round sequencer.
  always_comb begin
    fsm_d       = fsm_q;
    state_reg_d = state_reg_q;
    key_reg_d   = key_reg_q;
    out_data_d  = out_data_q;
    nib_d       = nib_q;
    rnd_d       = rnd_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_reg_d = in_data ^ in_key;
          key_reg_d   = in_key;
          nib_d       = 2'd0;
          rnd_d       = 4'd0;
          fsm_d       = SUB;
        end
      end
      SUB: begin
        case (nib_q)
          2'd0: state_reg_d[3:0]   = sbox_out;
          2'd1: state_reg_d[7:4]   = sbox_out;
          2'd2: state_reg_d[11:8]  = sbox_out;
          2'd3: state_reg_d[15:12] = sbox_out;
          default: state_reg_d = state_reg_q;
        endcase
        nib_d = nib_q + 2'd1;
        if (nib_q == 2'd3) begin
          fsm_d = PERM;
        end
      end
      PERM: begin
        key_reg_d   = key_next;
        state_reg_d = perm_w ^ key_next;
        if (rnd_q == LAST_RND) begin
          // out_data only changes here, so it holds the last result everywhere else.
          out_data_d = perm_w ^ key_next;
          fsm_d      = DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
          nib_d = 2'd0;
          fsm_d = SUB;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_reg_q <= 16'h0;
      key_reg_q   <= 16'h0;
      out_data_q  <= 16'h0;
      nib_q       <= 2'd0;
      rnd_q       <= 4'd0;
    end else begin
      fsm_q       <= fsm_d;
      state_reg_q <= state_reg_d;
      key_reg_q   <= key_reg_d;
      out_data_q  <= out_data_d;
      nib_q       <= nib_d;
      rnd_q       <= rnd_d;
    end
  end

endmodule

// File: tb/tb_sbox_round_ctrl.sv
// Directed bench for sbox_round_ctrl. It uses two instances: dut_a with
// ROUNDS=1 and dut_b with ROUNDS=4. Each instance has its own S-box.
// Expected results follow the KEY_ROTATE_EN macro when it is defined.
module tb_sbox_round_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [15:0] in_data_a, in_key_a, out_data_a;
  logic [3:0]  sbox_in_a, sbox_out_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [15:0] in_data_b, in_key_b, out_data_b;
  logic [3:0]  sbox_in_b, sbox_out_b;

  int errors = 0;
  int checks = 0;

  function automatic logic [3:0] sbox_f(input logic [3:0] x);
    case (x)
      4'h0: return 4'h0;  4'h1: return 4'h6;  4'h2: return 4'hB;  4'h3: return 4'h3;
      4'h4: return 4'hE;  4'h5: return 4'h5;  4'h6: return 4'hD;  4'h7: return 4'h8;
      4'h8: return 4'hC;  4'h9: return 4'h1;  4'hA: return 4'h7;  4'hB: return 4'hA;
      4'hC: return 4'h2;  4'hD: return 4'hF;  4'hE: return 4'h4;  default: return 4'h9;
    endcase
  endfunction

  assign sbox_out_a = sbox_f(sbox_in_a);
  assign sbox_out_b = sbox_f(sbox_in_b);

  sbox_round_ctrl #(.ROUNDS(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_key(in_key_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .sbox_in(sbox_in_a), .sbox_out(sbox_out_a), .busy(busy_a)
  );

  sbox_round_ctrl #(.ROUNDS(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_key(in_key_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .sbox_in(sbox_in_b), .sbox_out(sbox_out_b), .busy(busy_b)
  );

  // Reference model. Bit i moves to (4*i) mod 15, and bit 15 stays in place.
  function automatic logic [15:0] ref_enc(input logic [15:0] d, input logic [15:0] k,
                                          input int rounds);
    logic [15:0] s, t, p, kk;
    logic [3:0]  src;
    s  = d ^ k;
    kk = k;
    for (int r = 0; r < rounds; r++) begin
      t = {sbox_f(s[15:12]), sbox_f(s[11:8]), sbox_f(s[7:4]), sbox_f(s[3:0])};
      p = 16'h0;
      for (int i = 0; i < 16; i++) begin
        src = 4'(i);
        if (src != 4'd15) begin
          p[4'((4 * i) % 15)] = t[src];
        end else begin
          p[15] = t[15];
        end
      end
`ifdef KEY_ROTATE_EN
      kk = {kk[11:0], kk[15:12]};
`endif
      s = p ^ kk;
    end
    return s;
  endfunction

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count the negedges until out_valid goes high, starting from n0. The wait is bounded.
  task automatic wait_valid(input bit sel_b, input int n0, output int n);
    n = n0;
    while (((sel_b ? out_valid_b : out_valid_a) !== 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Send one block to dut_a and return the result and its latency in edges, then complete the handshake.
  task automatic run_a(input logic [15:0] d, input logic [15:0] k,
                       output logic [15:0] res, output int lat);
    in_data_a = d; in_key_a = k; in_valid_a = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0;
    wait_valid(1'b0, 0, lat);
    res = out_data_a;
    out_ready_a = 1'b1;
    @(negedge clk);
    out_ready_a = 1'b0;
  endtask

  task automatic run_b(input logic [15:0] d, input logic [15:0] k,
                       output logic [15:0] res, output int lat);
    in_data_b = d; in_key_b = k; in_valid_b = 1'b1;
    @(negedge clk);
    in_valid_b = 1'b0;
    wait_valid(1'b1, 0, lat);
    res = out_data_b;
    out_ready_b = 1'b1;
    @(negedge clk);
    out_ready_b = 1'b0;
  endtask

  initial begin
    logic [15:0] res, exp;
    int lat, n, bad;

    rst_n = 1'b0;
    in_valid_a = 1'b0; in_data_a = 16'h0; in_key_a = 16'h0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = 16'h0; in_key_b = 16'h0; out_ready_b = 1'b0;
    repeat (3) @(negedge clk);

    // Values held during reset.
    chk1("rst_in_ready", in_ready_a, 1'b1);
    chk1("rst_out_valid", out_valid_a, 1'b0);
    chk1("rst_busy", busy_a, 1'b0);
    chk16("rst_sbox_in", {12'h0, sbox_in_a}, 16'h0);
    chk16("rst_out_data", out_data_b, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // ROUNDS=1, data 0x0001, key 0: check the S-box input sequence and the latency.
    in_data_a = 16'h0001; in_key_a = 16'h0000; in_valid_a = 1'b1;
    @(negedge clk);
    in_valid_a = 1'b0;
    chk1("t1_busy", busy_a, 1'b1);
    chk1("t1_in_ready", in_ready_a, 1'b0);
    chk16("t1_sbox0", {12'h0, sbox_in_a}, 16'h1);
    @(negedge clk);
    chk16("t1_sbox1", {12'h0, sbox_in_a}, 16'h0);
    @(negedge clk);
    chk16("t1_sbox2", {12'h0, sbox_in_a}, 16'h0);
    @(negedge clk);
    chk16("t1_sbox3", {12'h0, sbox_in_a}, 16'h0);
    @(negedge clk);
    chk1("t1_perm_busy", busy_a, 1'b1);
    chk1("t1_perm_valid", out_valid_a, 1'b0);
    chk16("t1_perm_sbox", {12'h0, sbox_in_a}, 16'h0);
    wait_valid(1'b0, 4, lat);
    chkn("t1_latency", lat, 5);
    chk16("t1_data", out_data_a, 16'h0110);
    out_ready_a = 1'b1;
    @(negedge clk);
    out_ready_a = 1'b0;
    chk1("t1_valid_drop", out_valid_a, 1'b0);
    chk1("t1_idle", in_ready_a, 1'b1);
    chk16("t1_hold", out_data_a, 16'h0110);

    // ROUNDS=1, all-ones data.
    run_a(16'hFFFF, 16'h0000, res, lat);
    chkn("t2_latency", lat, 5);
    chk16("t2_data", res, 16'hF00F);

    // ROUNDS=1, key equal to data: the result depends on key rotation.
    run_a(16'h1234, 16'h1234, res, lat);
`ifdef KEY_ROTATE_EN
    chk16("t3_data", res, 16'h2341);
`else
    chk16("t3_data", res, 16'h1234);
`endif

    // ROUNDS=4: a second request arrives during SUB, then out_ready is held low for 3 DONE cycles.
    exp = ref_enc(16'hA5C3, 16'h3C5A, 4);
    in_data_b = 16'hA5C3; in_key_b = 16'h3C5A; in_valid_b = 1'b1;
    @(negedge clk);
    in_valid_b = 1'b0;
    n = 0; bad = 0;
    if (in_ready_b !== 1'b0 || busy_b !== 1'b1) bad++;
    @(negedge clk); n++;
    in_data_b = 16'hFFFF; in_key_b = 16'h1111; in_valid_b = 1'b1;
    if (in_ready_b !== 1'b0 || busy_b !== 1'b1) bad++;
    @(negedge clk); n++;
    in_valid_b = 1'b0;
    while (out_valid_b !== 1'b1 && n < 200) begin
      if (in_ready_b !== 1'b0 || busy_b !== 1'b1) bad++;
      @(negedge clk);
      n++;
    end
    chkn("t4_in_ready_low", bad, 0);
    chkn("t4_latency", n, 20);
    chk16("t4_data", out_data_b, exp);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk1("t4_valid_held", out_valid_b, 1'b1);
      chk16("t4_data_stable", out_data_b, exp);
      chk1("t4_in_ready_done", in_ready_b, 1'b0);
    end
    out_ready_b = 1'b1;
    @(negedge clk);
    out_ready_b = 1'b0;
    chk1("t4_idle", in_ready_b, 1'b1);
    chk1("t4_valid_drop", out_valid_b, 1'b0);
    @(negedge clk);
    chk1("t4_no_stray", busy_b, 1'b0);
    chk16("t4_hold", out_data_b, exp);

    // Reset during the second SUB cycle of round 2.
    in_data_b = 16'h1357; in_key_b = 16'h2468; in_valid_b = 1'b1;
    @(negedge clk);
    in_valid_b = 1'b0;
    repeat (6) @(negedge clk);
    chk1("t5_pre_busy", busy_b, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t5_in_ready", in_ready_b, 1'b1);
    chk1("t5_out_valid", out_valid_b, 1'b0);
    chk1("t5_busy", busy_b, 1'b0);
    chk16("t5_sbox_in", {12'h0, sbox_in_b}, 16'h0);
    chk16("t5_out_data", out_data_b, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_b(16'h0F1E, 16'hBEEF, res, lat);
    chkn("t5_next_latency", lat, 20);
    chk16("t5_next_data", res, ref_enc(16'h0F1E, 16'hBEEF, 4));

    // Back-to-back on ROUNDS=1 with out_ready held high.
    out_ready_a = 1'b1;
    in_data_a = 16'h00F0; in_key_a = 16'h0000; in_valid_a = 1'b1;
    @(negedge clk);
    in_data_a = 16'h0002;
    wait_valid(1'b0, 0, lat);
    chkn("t6_a_latency", lat, 5);
    chk16("t6_a_data", out_data_a, 16'h2002);
    @(negedge clk);
    chk1("t6_a_one_cycle", out_valid_a, 1'b0);
    chk1("t6_idle_gap", in_ready_a, 1'b1);
    @(negedge clk);
    chk1("t6_b_accepted", busy_a, 1'b1);
    chk1("t6_b_in_ready", in_ready_a, 1'b0);
    in_valid_a = 1'b0;
    wait_valid(1'b0, 0, lat);
    chkn("t6_b_latency", lat, 5);
    chk16("t6_b_data", out_data_a, 16'h1011);
    @(negedge clk);
    chk1("t6_b_one_cycle", out_valid_a, 1'b0);
    out_ready_a = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
